// File: rtl/tblink_rpc_pkt_arb.sv
// ---------------------------------------------------------------------------
// tblink_rpc_pkt_arb
//
// Packet-atomic round-robin arbiter. Merges N byte-wide ready/valid packet
// streams onto one output stream. A packet is a header byte, a count byte C,
// then C+1 payload bytes. Once a requester is granted, its whole packet is
// forwarded before any other requester is considered. A halt request stops
// new grants at packet boundaries only.
//
// Ports:
//   uclock     clock, rising edge
//   reset_n    asynchronous active-low reset
//   hreq_i     halt request, blocks new grants
//   hreq_o     halt acknowledge, high while hreq_i=1 and the arbiter is idle
//   req_valid  per-requester valid (bit i = requester i)
//   req_dat    per-requester data (byte i at [8i+7:8i])
//   req_ready  per-requester ready
//   out_valid  output stream valid
//   out_dat    output stream data
//   out_ready  output stream ready
//   gnt_id     index of the granted requester, meaningful while busy=1
//   busy       a packet is in flight
//   pkt_done   one-cycle pulse in the cycle after the last payload beat
// ---------------------------------------------------------------------------
module tblink_rpc_pkt_arb #(
  parameter int N = 2
) (
  input  logic           uclock,
  input  logic           reset_n,
  input  logic           hreq_i,
  output logic           hreq_o,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_dat,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [7:0]     out_dat,
  input  logic           out_ready,
  output logic [2:0]     gnt_id,
  output logic           busy,
  output logic           pkt_done
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CNT,
    PAY
  } state_t;

  state_t     state;
  logic [2:0] rr_ptr;
  logic [7:0] count;

  // Requester buses widened to the full 8-entry space so that the 3-bit
  // gnt_id can index them directly for any legal N.
  logic [7:0]  valid_ext;
  logic [63:0] dat_ext;
  logic [7:0]  dat_arr [8];

  assign valid_ext = 8'(req_valid);
  assign dat_ext   = 64'(req_dat);

  for (genvar g = 0; g < 8; g++) begin : g_dat
    assign dat_arr[g] = dat_ext[8*g +: 8];
  end

  logic in_pkt;
  logic xfer;

  assign in_pkt    = (state != IDLE);
  assign busy      = in_pkt;
  assign out_dat   = dat_arr[gnt_id];
  assign out_valid = in_pkt & valid_ext[gnt_id];
  assign xfer      = out_valid & out_ready;
  assign hreq_o    = hreq_i & (state == IDLE);

  for (genvar g = 0; g < N; g++) begin : g_ready
    assign req_ready[g] = out_ready & in_pkt & (gnt_id == 3'(g));
  end

  // Round-robin search: first valid index starting at rr_ptr, wrapping mod N.
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [3:0] cand;

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      if (!pick_found && valid_ext[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // Pointer for the next arbitration: the requester after the one just served.
  logic [2:0] next_ptr;
  assign next_ptr = (gnt_id == 3'(N-1)) ? 3'd0 : gnt_id + 3'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      count    <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          // Costs one bubble cycle per packet; halt only takes effect here,
          // so a packet in flight is never truncated.
          if (!hreq_i && pick_found) begin
            gnt_id <= pick_idx;
            state  <= HDR;
          end
        end
        HDR: begin
          if (xfer) state <= CNT;
        end
        CNT: begin
          if (xfer) begin
            count <= out_dat;
            state <= PAY;
          end
        end
        PAY: begin
          // count holds the number of payload beats still to follow this one.
          if (xfer) begin
            if (count == 8'd0) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              pkt_done <= 1'b1;
            end else begin
              count <= count - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tblink_rpc_pkt_arb.sv
// ---------------------------------------------------------------------------
// tb_tblink_rpc_pkt_arb
//
// Self-checking bench for tblink_rpc_pkt_arb (N=2). Requesters are byte
// queues driven with ready/valid rules; a transaction-level reference model
// (grant owner, byte position in packet, round-robin pointer) predicts every
// output each cycle. Inputs change on the falling edge and outputs are
// sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_tblink_rpc_pkt_arb;

  localparam int N = 2;

  logic           uclock = 1'b0;
  logic           reset_n;
  logic           hreq_i;
  logic           hreq_o;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_dat;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_dat;
  logic           out_ready;
  logic [2:0]     gnt_id;
  logic           busy;
  logic           pkt_done;

  tblink_rpc_pkt_arb #(.N(N)) dut (
    .uclock    (uclock),
    .reset_n   (reset_n),
    .hreq_i    (hreq_i),
    .hreq_o    (hreq_o),
    .req_valid (req_valid),
    .req_dat   (req_dat),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_dat   (out_dat),
    .out_ready (out_ready),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  always #5 uclock = ~uclock;

  // Source side
  logic [7:0] src_q [N][$];
  bit         drv_v [N];
  logic [7:0] drv_d [N];
  int         valid_pct;
  int         rdy_mode;   // 0: always ready, 1: toggle, 2: random
  bit         rdy_tog;
  bit         halt_cmd;

  // Reference model
  bit m_active;
  int m_gnt;
  int m_rr;
  int m_pos;
  int m_len;
  bit m_done;

  // Observation logs
  logic [7:0] out_log [$];
  int         grant_log [$];
  int         done_cnt;
  int         cyc;
  int         first_v;
  int         first_x;
  bit         prev_busy;
  bit         r1_viol;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int r, input logic [7:0] hdr, input int c, input logic [7:0] seed);
    src_q[r].push_back(hdr);
    src_q[r].push_back(8'(c));
    for (int k = 0; k <= c; k++) src_q[r].push_back(seed + 8'(k));
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
    done_cnt = 0;
    first_v  = -1;
    first_x  = -1;
    r1_viol  = 1'b0;
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_gnt     = 0;
    m_rr      = 0;
    m_pos     = 0;
    m_len     = 0;
    m_done    = 1'b0;
    prev_busy = 1'b0;
  endtask

  // One clock cycle: drive, settle, compare against the model, advance model.
  task automatic cycle();
    bit any_v;
    @(negedge uclock);
    hreq_i = halt_cmd;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1: begin rdy_tog = ~rdy_tog; out_ready = rdy_tog; end
      default: out_ready = ($urandom_range(99) < 70);
    endcase
    for (int i = 0; i < N; i++) begin
      if (!drv_v[i] && src_q[i].size() > 0 && $urandom_range(99) < valid_pct)
        drv_v[i] = 1'b1;
      drv_d[i] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      req_valid[i]       = drv_v[i];
      req_dat[8*i +: 8]  = drv_d[i];
    end
    #1;

    // Expected outputs
    check("busy", busy, m_active);
    check("pkt_done", pkt_done, m_done);
    check("hreq_o", hreq_o, hreq_i & !m_active);
    if (m_active) begin
      check("gnt_id", gnt_id, m_gnt);
      check("out_valid", out_valid, drv_v[m_gnt]);
      if (drv_v[m_gnt]) check("out_dat", out_dat, drv_d[m_gnt]);
      check("req_ready", req_ready, out_ready ? (1 << m_gnt) : 0);
    end else begin
      check("out_valid_idle", out_valid, 0);
      check("req_ready_idle", req_ready, 0);
    end

    // Bookkeeping from observed outputs
    if (pkt_done) done_cnt++;
    if (busy && !prev_busy) grant_log.push_back(int'(gnt_id));
    prev_busy = busy;
    if (out_valid && out_ready) out_log.push_back(out_dat);
    if (first_v < 0 && |req_valid) first_v = cyc;
    if (first_x < 0 && out_valid && out_ready) first_x = cyc;
    if (busy && gnt_id == 3'd0 && req_ready[1]) r1_viol = 1'b1;

    // Model update for the coming rising edge
    m_done = 1'b0;
    any_v  = 1'b0;
    if (!m_active) begin
      if (!hreq_i) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (!any_v && drv_v[idx]) begin
            any_v    = 1'b1;
            m_gnt    = idx;
            m_active = 1'b1;
            m_pos    = 0;
          end
        end
      end
    end else if (drv_v[m_gnt] && out_ready) begin
      if (m_pos == 1) m_len = int'(drv_d[m_gnt]) + 3;
      m_pos++;
      if (m_pos >= 3 && m_pos == m_len) begin
        m_active = 1'b0;
        m_rr     = (m_gnt + 1) % N;
        m_done   = 1'b1;
      end
    end

    // Source pops on handshake
    for (int i = 0; i < N; i++) begin
      if (drv_v[i] && req_ready[i]) begin
        void'(src_q[i].pop_front());
        drv_v[i] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input int n, input int budget, input string tag);
    int b = 0;
    while (done_cnt < n && b < budget) begin
      cycle();
      b++;
    end
    check(tag, done_cnt, n);
  endtask

  task automatic run_until_beats(input int n, input int budget, input string tag);
    int b = 0;
    while (out_log.size() < n && b < budget) begin
      cycle();
      b++;
    end
    check(tag, out_log.size(), n);
  endtask

  task automatic check_pkt(input string tag, input int start, input logic [7:0] hdr,
                           input int c, input logic [7:0] seed);
    logic [7:0] exp;
    for (int k = 0; k < c + 3; k++) begin
      exp = (k == 0) ? hdr : (k == 1) ? 8'(c) : seed + 8'(k - 2);
      if (start + k < out_log.size()) check(tag, out_log[start + k], exp);
      else check(tag, 32'hDEAD, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge uclock);
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_hreq_o", hreq_o, hreq_i);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      drv_v[i] = 1'b0;
    end
    req_valid = '0;
    model_reset();
    @(negedge uclock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    hreq_i    = 1'b0;
    halt_cmd  = 1'b0;
    req_valid = '0;
    req_dat   = '0;
    out_ready = 1'b0;
    rdy_mode  = 0;
    rdy_tog   = 1'b0;
    valid_pct = 100;
    cyc       = 0;
    for (int i = 0; i < N; i++) drv_v[i] = 1'b0;
    model_reset();
    clear_logs();

    // Reset state
    @(negedge uclock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_pkt_done", pkt_done, 0);
    check("reset_gnt_id", gnt_id, 0);
    @(negedge uclock);
    reset_n = 1'b1;

    // 1: single packet from requester 0
    clear_logs();
    src_q[0].push_back(8'h05);
    src_q[0].push_back(8'h02);
    src_q[0].push_back(8'hA1);
    src_q[0].push_back(8'hA2);
    src_q[0].push_back(8'hA3);
    run_until_done(1, 50, "t1_done");
    check("t1_len", out_log.size(), 5);
    check_pkt("t1_data", 0, 8'h05, 2, 8'hA1);
    check("t1_latency", first_x - first_v, 1);
    for (int k = 0; k < 3; k++) cycle();
    check("t1_busy_after", busy, 0);
    check("t1_done_once", done_cnt, 1);

    // 2: both requesters continuously valid, 3-byte packets; pointer is at 1
    clear_logs();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 8'h10 + 8'(p), 0, 8'h80 + 8'(p));
      push_pkt(1, 8'h20 + 8'(p), 0, 8'h90 + 8'(p));
    end
    run_until_done(8, 200, "t2_done");
    check("t2_beats", out_log.size(), 24);
    check("t2_grants", grant_log.size(), 8);
    for (int j = 0; j < grant_log.size(); j++) check("t2_alternate", grant_log[j], (j + 1) % 2);

    // 3: backpressure, out_ready toggling during a C=3 packet
    clear_logs();
    rdy_mode = 1;
    push_pkt(0, 8'h13, 3, 8'h31);
    begin
      int b = 0;
      while (!busy && b < 10) begin cycle(); b++; end
    end
    push_pkt(1, 8'h23, 1, 8'h70);
    run_until_done(1, 60, "t3_done0");
    check("t3_beats", out_log.size(), 6);
    check_pkt("t3_data", 0, 8'h13, 3, 8'h31);
    check("t3_r1_ready_blocked", r1_viol, 0);
    run_until_done(2, 60, "t3_done1");
    check_pkt("t3_data1", 6, 8'h23, 1, 8'h70);
    rdy_mode = 0;

    // 4: halt asserted mid-payload of a C=4 packet
    clear_logs();
    push_pkt(0, 8'h44, 4, 8'h50);
    push_pkt(1, 8'h45, 0, 8'h60);
    run_until_beats(3, 40, "t4_reach_payload");
    halt_cmd = 1'b1;
    run_until_done(1, 40, "t4_done");
    check("t4_full_packet", out_log.size(), 7);
    for (int k = 0; k < 5; k++) cycle();
    check("t4_hreq_o", hreq_o, 1);
    check("t4_no_grant", busy, 0);
    check("t4_grant_count", grant_log.size(), 1);
    halt_cmd = 1'b0;
    cycle();
    cycle();
    check("t4_resume_busy", busy, 1);
    check("t4_resume_gnt", gnt_id, 1);
    run_until_done(2, 40, "t4_done1");

    // 5: C=255 packet from requester 1, pointer then wraps to 0
    clear_logs();
    push_pkt(1, 8'h7F, 255, 8'h00);
    run_until_done(1, 400, "t5_done");
    check("t5_beats", out_log.size(), 258);
    check("t5_gnt", grant_log[0], 1);
    push_pkt(0, 8'h01, 0, 8'hC0);
    push_pkt(1, 8'h02, 0, 8'hD0);
    run_until_done(3, 60, "t5_after");
    check("t5_wrap_first", grant_log[1], 0);
    check("t5_wrap_second", grant_log[2], 1);

    // 6: reset mid-payload while requester 1 is granted
    clear_logs();
    push_pkt(0, 8'h61, 0, 8'hE0);
    push_pkt(1, 8'h62, 10, 8'hF0);
    run_until_beats(7, 60, "t6_reach_payload");
    check("t6_gnt_before", gnt_id, 1);
    do_reset();
    check("t6_no_done", done_cnt, 1);
    clear_logs();
    push_pkt(0, 8'h63, 0, 8'h11);
    push_pkt(1, 8'h64, 0, 8'h22);
    run_until_done(2, 60, "t6_after");
    check("t6_first_gnt", grant_log[0], 0);

    // 7: randomized traffic, stalls, backpressure and halts
    clear_logs();
    valid_pct = 60;
    rdy_mode  = 2;
    for (int p = 0; p < 30; p++)
      for (int r = 0; r < N; r++)
        push_pkt(r, 8'($urandom_range(127)), $urandom_range(20), 8'($urandom));
    begin
      int b = 0;
      while ((src_q[0].size() > 0 || src_q[1].size() > 0 || m_active) && b < 20000) begin
        if (!halt_cmd) halt_cmd = ($urandom_range(99) < 3);
        else halt_cmd = ($urandom_range(99) < 70);
        cycle();
        b++;
      end
    end
    halt_cmd = 1'b0;
    cycle();
    check("t7_packets", done_cnt, 60);
    check("t7_drained", src_q[0].size() + src_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
